axi_mm_patgen_top: RTL and testbench

- Pattern generator for the transmit side of the AXIST simplex test path. It is the source end that the follower-side pattern checker compares against.
- Drives the AXIST data stream with a valid/ready handshake.
- Mirrors every accepted beat into the checker's expected-data FIFO via patgen_din/patgen_din_wr, so both views always match beat-for-beat.
- Supports a counted burst (patgen_cnt beats) and a continuous mode (cntuspatt_en).

---
 rtl/axi_mm_patgen_pkg.sv | 23 ++
 rtl/axi_mm_patgen_lfsr.sv | 38 +++
 rtl/axi_mm_patgen_top.sv | 166 ++++++++++++++++
 tb/tb_axi_mm_patgen_top.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mm_patgen_pkg.sv
// Shared definitions for the AXIST transmit pattern generator.
// Contents: LFSR polynomial, default seed, lane width, FSM state encoding,
// and the helper that builds one 128-bit beat word from LFSR state and index.
package axi_mm_patgen_pkg;

  localparam logic [31:0] LFSR_POLY    = 32'h0040_0007;
  localparam logic [31:0] DEFAULT_SEED = 32'h1234_5678;
  localparam int          LANE_W       = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_e;

  // Beat layout: {lfsr, ~lfsr, zero-extended index, lfsr ^ replicated index}
  function automatic logic [LANE_W-1:0] beat_word(input logic [31:0] lfsr,
                                                  input logic [7:0]  idx);
    return {lfsr, ~lfsr, 24'h0, idx, lfsr ^ {4{idx}}};
  endfunction

endpackage

// File: rtl/axi_mm_patgen_lfsr.sv
// 32-bit Galois LFSR (left shift) used as the pattern source.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset, loads SEED
//   load_i - synchronous reload with SEED (takes priority over adv_i)
//   adv_i  - advance one step
//   lfsr_o - current 32-bit state
module axi_mm_patgen_lfsr
  import axi_mm_patgen_pkg::*;
#(
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        adv_i,
  output logic [31:0] lfsr_o
);

  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED;
    end else if (adv_i) begin
      lfsr_d = {lfsr_q[30:0], 1'b0} ^ (lfsr_q[31] ? LFSR_POLY : 32'h0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/axi_mm_patgen_top.sv
// AXIST transmit pattern generator. Streams LFSR-derived beats with a
// valid/ready handshake and mirrors each accepted beat to the checker's
// expected-data FIFO. Counted runs (patgen_cnt beats, 0 = 256) or continuous
// mode (cntuspatt_en).
//
// Handshake: a beat transfers on a cycle where axist_valid & axist_tready.
// Once axist_valid is high, axist_valid and axist_data hold until that
// transfer; chkr_fifo_full only gates raising axist_valid for a new beat.
//
// Ports:
//   wrclk, rst           - clock, async active-high reset
//   patgen_en            - rising edge starts a counted run
//   patgen_cnt[7:0]      - beats per counted run, 0 means 256
//   cntuspatt_en         - continuous mode enable (rising edge also starts)
//   chkr_fifo_full       - blocks launch of a new beat
//   axist_tready         - sink ready
//   axist_valid/_data    - beat stream
//   patgen_din/_din_wr   - copy of accepted beat + strobe, same cycle as accept
//   patgen_busy          - high in LOAD and SEND
//   patgen_done          - one-cycle pulse at run end
//   dbg_state[1:0]       - FSM state for observation
//   err_inj              - only with AXI_MM_PATGEN_ERR_INJ_EN: flips bit 0 of
//                          the next launched beat on axist_data only
module axi_mm_patgen_top
  import axi_mm_patgen_pkg::*;
#(
  parameter int          LEADER_MODE = 1,
  parameter logic [31:0] SEED        = DEFAULT_SEED,
  localparam int         DW          = LEADER_MODE * LANE_W
) (
  input  logic          wrclk,
  input  logic          rst,
  input  logic          patgen_en,
  input  logic [7:0]    patgen_cnt,
  input  logic          cntuspatt_en,
  input  logic          chkr_fifo_full,
  input  logic          axist_tready,
`ifdef AXI_MM_PATGEN_ERR_INJ_EN
  input  logic          err_inj,
`endif
  output logic          axist_valid,
  output logic [DW-1:0] axist_data,
  output logic [DW-1:0] patgen_din,
  output logic          patgen_din_wr,
  output logic          patgen_busy,
  output logic          patgen_done,
  output logic [1:0]    dbg_state
);

  state_e      state_q, state_d;
  logic        en_q, en_prev_q, cnt_en_q, cnt_en_prev_q;
  logic        valid_q, valid_d;
  logic [7:0]  idx_q, idx_d;
  logic [8:0]  rem_q, rem_d;
  logic        cont_q, cont_d;
  logic        lfsr_load, launch, more;
  logic        start, accept, corrupt_q;
  logic [31:0] lfsr;
  logic [DW-1:0] pristine;

  axi_mm_patgen_lfsr #(.SEED(SEED)) u_lfsr (
    .clk_i  (wrclk),
    .rst_i  (rst),
    .load_i (lfsr_load),
    .adv_i  (accept),
    .lfsr_o (lfsr)
  );

  always_ff @(posedge wrclk or posedge rst) begin
    if (rst) begin
      en_q          <= 1'b0;
      en_prev_q     <= 1'b0;
      cnt_en_q      <= 1'b0;
      cnt_en_prev_q <= 1'b0;
    end else begin
      en_q          <= patgen_en;
      en_prev_q     <= en_q;
      cnt_en_q      <= cntuspatt_en;
      cnt_en_prev_q <= cnt_en_q;
    end
  end

  assign start  = (en_q & ~en_prev_q) | (cnt_en_q & ~cnt_en_prev_q);
  assign accept = valid_q & axist_tready;

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    cont_d    = cont_q;
    lfsr_load = 1'b0;
    launch    = 1'b0;
    more      = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        lfsr_load = 1'b1;
        idx_d     = 8'd0;
        rem_d     = (patgen_cnt == 8'd0) ? 9'd256 : {1'b0, patgen_cnt};
        cont_d    = cnt_en_q;
        valid_d   = 1'b0;
        state_d   = SEND;
      end
      SEND: begin
        if (accept) begin
          idx_d = idx_q + 8'd1;
          rem_d = rem_q - 9'd1;
        end
        // "more" = another beat may be launched after this cycle
        if (cont_q) more = cnt_en_q;
        else        more = accept ? (rem_q > 9'd1) : (rem_q != 9'd0);
        launch  = (~valid_q | accept) & ~chkr_fifo_full & more;
        valid_d = (valid_q & ~accept) | launch;
        if (!more && (!valid_q || accept)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wrclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      idx_q   <= 8'd0;
      rem_q   <= 9'd0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      cont_q  <= cont_d;
    end
  end

`ifdef AXI_MM_PATGEN_ERR_INJ_EN
  logic arm_q;
  // arm_q waits for the next launch; corrupt_q marks the beat on the bus
  always_ff @(posedge wrclk or posedge rst) begin
    if (rst) begin
      arm_q     <= 1'b0;
      corrupt_q <= 1'b0;
    end else begin
      arm_q <= (arm_q & ~launch) | err_inj;
      if (launch)      corrupt_q <= arm_q;
      else if (accept) corrupt_q <= 1'b0;
    end
  end
`else
  assign corrupt_q = 1'b0;
`endif

  // Data is derived from LFSR/index registers, which only move on accept,
  // so it is stable while a beat is pending. Gated to zero when idle.
  assign pristine      = {LEADER_MODE{beat_word(lfsr, idx_q)}};
  assign axist_valid   = valid_q;
  assign axist_data    = valid_q ? (pristine ^ {{(DW-1){1'b0}}, corrupt_q}) : '0;
  assign patgen_din    = accept ? pristine : '0;
  assign patgen_din_wr = accept;
  assign patgen_busy   = (state_q == LOAD) || (state_q == SEND);
  assign patgen_done   = (state_q == DONE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_axi_mm_patgen_top.sv
// Bench for axi_mm_patgen_top (LEADER_MODE = 1). Build with
// AXI_MM_PATGEN_ERR_INJ_EN defined to also exercise error injection.
module tb_axi_mm_patgen_top;

  localparam logic [31:0] SEED = 32'h1234_5678;
  localparam logic [31:0] POLY = 32'h0040_0007;

  logic         wrclk = 1'b0;
  logic         rst;
  logic         patgen_en, cntuspatt_en, chkr_fifo_full, axist_tready;
  logic [7:0]   patgen_cnt;
  logic         err_inj;
  logic         axist_valid, patgen_din_wr, patgen_busy, patgen_done;
  logic [127:0] axist_data, patgen_din;
  logic [1:0]   dbg_state;

  axi_mm_patgen_top dut (
    .wrclk          (wrclk),
    .rst            (rst),
    .patgen_en      (patgen_en),
    .patgen_cnt     (patgen_cnt),
    .cntuspatt_en   (cntuspatt_en),
    .chkr_fifo_full (chkr_fifo_full),
    .axist_tready   (axist_tready),
`ifdef AXI_MM_PATGEN_ERR_INJ_EN
    .err_inj        (err_inj),
`endif
    .axist_valid    (axist_valid),
    .axist_data     (axist_data),
    .patgen_din     (patgen_din),
    .patgen_din_wr  (patgen_din_wr),
    .patgen_busy    (patgen_busy),
    .patgen_done    (patgen_done),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 wrclk = ~wrclk;

  // ---------------- scoreboard state ----------------
  logic [127:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;
  int flips    = 0;
  logic         pend;
  logic [127:0] pend_data;
  logic [127:0] e;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {l[30:0], 1'b0} ^ (l[31] ? POLY : 32'h0);
  endfunction

  function automatic logic [127:0] exp_word(input logic [31:0] l, input logic [7:0] b);
    logic [31:0] b4;
    b4 = {b, b, b, b};
    return {l, ~l, 24'h0, b, l ^ b4};
  endfunction

  task automatic push_run(input int n);
    logic [31:0] l;
    l = SEED;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_word(l, i[7:0]));
      l = lfsr_next(l);
    end
  endtask

  // ---------------- monitor (samples on negedge) ----------------
  always @(negedge wrclk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      check("din_wr_vs_accept", patgen_din_wr, axist_valid & axist_tready);
      if (pend) begin
        check("hold_valid", axist_valid, 1'b1);
        check("hold_data", axist_data, pend_data);
      end
      if (patgen_done) done_cnt++;
      if (patgen_din_wr) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          check("sb_underflow", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("din_vs_exp", patgen_din, e);
`ifdef AXI_MM_PATGEN_ERR_INJ_EN
          if ((axist_data ^ e) == 128'h1) flips++;
          else check("data_vs_exp", axist_data, e);
`else
          check("data_vs_exp", axist_data, e);
`endif
        end
      end
      pend      = axist_valid & ~axist_tready;
      pend_data = axist_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge wrclk);
    #1;
  endtask

  task automatic pulse_en(input int cnt_in);
    patgen_cnt = cnt_in[7:0];
    patgen_en  = 1'b1;
    step();
    patgen_en  = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int limit, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      step();
      if (done_cnt != d0) got = 1'b1;
    end
    check({name, "_done_seen"}, got, 1'b1);
  endtask

  task automatic do_run(input int cnt_in, input int pct, input int n_exp, input string name);
    int a0, d0, first, last, prev;
    bit got;
    push_run(n_exp);
    a0 = acc_cnt;
    d0 = done_cnt;
    axist_tready = ($urandom_range(1, 100) <= pct);
    pulse_en(cnt_in);
    got = 1'b0; first = -1; last = -1; prev = acc_cnt;
    for (int i = 0; i < 3000 && !got; i++) begin
      axist_tready = ($urandom_range(1, 100) <= pct);
      step();
      if (acc_cnt != prev) begin
        if (first < 0) first = i;
        last = i;
        prev = acc_cnt;
      end
      if (done_cnt != d0) got = 1'b1;
    end
    check({name, "_done_seen"}, got, 1'b1);
    check({name, "_beats"}, acc_cnt - a0, n_exp);
    check({name, "_sb_empty"}, exp_q.size(), 0);
    if (pct == 100) check({name, "_back2back"}, last - first, n_exp - 1);
    repeat (2) step();
    check({name, "_one_done"}, done_cnt - d0, 1);
    check({name, "_busy_low"}, patgen_busy, 1'b0);
    exp_q.delete();
  endtask

  typedef struct {
    int    cnt_in;
    int    ready_pct;
    int    exp_beats;
    string name;
  } run_t;

  run_t runs[5];

  // ---------------- main sequence ----------------
  initial begin
    int a0, d0, f0, n;
    bit seen, hit;
    logic [127:0] held;

    runs[0] = '{4,   100, 4,   "cnt4"};
    runs[1] = '{0,   100, 256, "cnt256"};
    runs[2] = '{10,  50,  10,  "bp10"};
    runs[3] = '{1,   100, 1,   "cnt1"};
    runs[4] = '{7,   30,  7,   "bp7"};

    rst = 1'b1; patgen_en = 1'b0; cntuspatt_en = 1'b0; chkr_fifo_full = 1'b0;
    axist_tready = 1'b0; patgen_cnt = 8'd0; err_inj = 1'b0;
    repeat (3) step();
    check("rst_valid", axist_valid, 1'b0);
    check("rst_data", axist_data, 128'h0);
    check("rst_din_wr", patgen_din_wr, 1'b0);
    check("rst_busy", patgen_busy, 1'b0);
    check("rst_done", patgen_done, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    rst = 1'b0;
    repeat (2) step();

    // table-driven counted runs
    foreach (runs[k]) do_run(runs[k].cnt_in, runs[k].ready_pct, runs[k].exp_beats, runs[k].name);

    // fifo full before launch, then during a pending beat
    push_run(2);
    a0 = acc_cnt; d0 = done_cnt;
    chkr_fifo_full = 1'b1; axist_tready = 1'b0;
    pulse_en(2);
    seen = 1'b0;
    repeat (12) begin
      step();
      if (axist_valid) seen = 1'b1;
    end
    check("full_blocks_launch", seen, 1'b0);
    chkr_fifo_full = 1'b0;
    step();
    check("launch_after_release", axist_valid, 1'b1);
    held = axist_data;
    chkr_fifo_full = 1'b1;
    repeat (3) step();
    check("pending_under_full", axist_valid, 1'b1);
    check("pending_data_held", axist_data, held);
    axist_tready = 1'b1;
    step();
    check("accept_under_full", acc_cnt - a0, 1);
    seen = 1'b0;
    repeat (4) begin
      if (axist_valid) seen = 1'b1;
      step();
    end
    check("full_blocks_next", seen, 1'b0);
    chkr_fifo_full = 1'b0;
    wait_done(d0, 50, "full");
    check("full_beats", acc_cnt - a0, 2);
    exp_q.delete();
    repeat (2) step();

    // continuous mode across the index wrap
    push_run(400);
    a0 = acc_cnt; d0 = done_cnt;
    axist_tready = 1'b1;
    cntuspatt_en = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      step();
      if (acc_cnt - a0 >= 300) hit = 1'b1;
    end
    check("cont_reached_300", hit, 1'b1);
    cntuspatt_en = 1'b0;
    wait_done(d0, 50, "cont");
    n = acc_cnt - a0;
    check("cont_beats_range", (n >= 300) && (n <= 304), 1'b1);
    repeat (3) step();
    check("cont_one_done", done_cnt - d0, 1);
    check("cont_busy_low", patgen_busy, 1'b0);
    exp_q.delete();

    // reset in the middle of a run
    push_run(10);
    a0 = acc_cnt; d0 = done_cnt;
    axist_tready = 1'b1;
    pulse_en(10);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      step();
      if (acc_cnt - a0 >= 3) hit = 1'b1;
    end
    check("mid_reached_3", hit, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", axist_valid, 1'b0);
    check("mid_rst_data", axist_data, 128'h0);
    check("mid_rst_din", patgen_din, 128'h0);
    check("mid_rst_din_wr", patgen_din_wr, 1'b0);
    check("mid_rst_busy", patgen_busy, 1'b0);
    check("mid_rst_done", patgen_done, 1'b0);
    repeat (2) step();
    rst = 1'b0;
    exp_q.delete();
    repeat (4) step();
    check("no_done_after_abort", done_cnt - d0, 0);
    do_run(3, 100, 3, "restart");

`ifdef AXI_MM_PATGEN_ERR_INJ_EN
    push_run(6);
    f0 = flips; d0 = done_cnt;
    axist_tready = 1'b1;
    pulse_en(6);
    step();
    err_inj = 1'b1;
    step();
    err_inj = 1'b0;
    wait_done(d0, 100, "errinj");
    check("errinj_one_flip", flips - f0, 1);
    exp_q.delete();
`else
    f0 = flips;
    check("no_flips_default", f0, 0);
`endif

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
